us_ranger_multi: RTL

- Parametrised multi-channel successor to the single-channel ultrasonic distance meter core.
- Sequences ping/echo measurements round-robin across N_CH transducer channels, with single-shot or continuous sweep modes.
- Adds a blanking window and a timeout, and reports a per-measurement result stream with a valid strobe.
- Sits between the transducer pins (sig_mod out, sig_in in) and the display/readout logic.

---
 rtl/us_ranger_multi.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/us_ranger_multi.sv
// rtl/us_ranger_multi.sv - multi-channel ultrasonic ping/echo range sequencer
//
// Sequences ping/echo measurements round-robin over the enabled transducer
// channels and emits one result per measurement.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        one-cycle sweep request (honoured only in IDLE with ch_en != 0)
//   cont         1 = start another sweep when the current one ends
//   ch_en        channel enable mask, latched at sweep start
//   sig_in       echo receiver inputs (asynchronous to clk)
//   sig_mod      carrier burst outputs, only the active channel toggles
//   busy         high while a sweep is in progress
//   dist_valid   one-cycle result strobe
//   dist_ch      channel of the latest result
//   dist_cm      latest distance in cm
//   dist_timeout latest result came from the range timeout
module us_ranger_multi #(
    parameter int N_CH         = 4,
    parameter int HALF_PER     = 1250,
    parameter int BURST_PULSES = 8,
    parameter int CM_TICKS     = 5831,
    parameter int BLANK_CM     = 4,
    parameter int MAX_CM       = 400,
    parameter int DIST_W       = 9,
    parameter int GUARD        = 1000000,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [N_CH-1:0]   sig_in,
    output logic [N_CH-1:0]   sig_mod,
    output logic              busy,
    output logic              dist_valid,
    output logic [CH_W-1:0]   dist_ch,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_timeout
);

    // One timer serves both the carrier half-period and the guard interval,
    // since PING and GUARD never overlap.
    localparam int TMR_MAX = (HALF_PER > GUARD) ? HALF_PER : GUARD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int HIDX_W  = (2 * BURST_PULSES > 1) ? $clog2(2 * BURST_PULSES) : 1;
    localparam int PRE_W   = (CM_TICKS > 1) ? $clog2(CM_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PING,
        S_LISTEN,
        S_REPORT,
        S_GUARD
    } state_t;

    state_t              state, state_n;
    logic [CH_W-1:0]     ch, ch_n;
    logic [N_CH-1:0]     mask, mask_n;
    logic [TMR_W-1:0]    tmr, tmr_n;
    logic [HIDX_W-1:0]   half_idx, hidx_n;
    logic [PRE_W-1:0]    pre, pre_n;
    logic [DIST_W-1:0]   cm_cnt, cm_n;
    logic [CH_W-1:0]     res_ch, res_ch_n;
    logic [DIST_W-1:0]   res_cm, res_cm_n;
    logic                res_to, res_to_n;
    logic [N_CH-1:0]     sync1, sync2, prev;
    logic [N_CH-1:0]     above;
    logic                echo;
    logic                go_ping;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
        lowest_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CH_W'(i);
        end
    endfunction

    function automatic logic [N_CH-1:0] above_mask(input logic [N_CH-1:0] m,
                                                   input logic [CH_W-1:0] c);
        above_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            above_mask[i] = m[i] && (i > int'(c));
        end
    endfunction

    // Every channel keeps its own edge history so switching the active
    // channel never fabricates an edge from a level that was already high.
    assign echo = sync2[ch] & ~prev[ch];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            mask     <= '0;
            tmr      <= '0;
            half_idx <= '0;
            pre      <= '0;
            cm_cnt   <= '0;
            res_ch   <= '0;
            res_cm   <= '0;
            res_to   <= 1'b0;
        end else begin
            state    <= state_n;
            ch       <= ch_n;
            mask     <= mask_n;
            tmr      <= tmr_n;
            half_idx <= hidx_n;
            pre      <= pre_n;
            cm_cnt   <= cm_n;
            res_ch   <= res_ch_n;
            res_cm   <= res_cm_n;
            res_to   <= res_to_n;
        end
    end

    always_comb begin
        state_n  = state;
        ch_n     = ch;
        mask_n   = mask;
        tmr_n    = tmr;
        hidx_n   = half_idx;
        pre_n    = pre;
        cm_n     = cm_cnt;
        res_ch_n = res_ch;
        res_cm_n = res_cm;
        res_to_n = res_to;
        go_ping  = 1'b0;
        above    = above_mask(mask, ch);

        case (state)
            S_IDLE: begin
                if (start && ch_en != '0) begin
                    mask_n  = ch_en;
                    ch_n    = lowest_ch(ch_en);
                    go_ping = 1'b1;
                end
            end
            S_PING: begin
                if (tmr == TMR_W'(HALF_PER - 1)) begin
                    tmr_n = '0;
                    if (half_idx == HIDX_W'(2 * BURST_PULSES - 1)) begin
                        state_n = S_LISTEN;
                    end else begin
                        hidx_n = half_idx + HIDX_W'(1);
                    end
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            S_LISTEN: begin
                // Echo is tested first so it wins a tie with the timeout.
                if (echo && cm_cnt >= DIST_W'(BLANK_CM)) begin
                    state_n  = S_REPORT;
                    res_ch_n = ch;
                    res_cm_n = cm_cnt;
                    res_to_n = 1'b0;
                end else if (cm_cnt == DIST_W'(MAX_CM)) begin
                    state_n  = S_REPORT;
                    res_ch_n = ch;
                    res_cm_n = DIST_W'(MAX_CM);
                    res_to_n = 1'b1;
                end
            end
            S_REPORT: begin
                state_n = S_GUARD;
                tmr_n   = '0;
            end
            S_GUARD: begin
                if (tmr == TMR_W'(GUARD - 1)) begin
                    if (above != '0) begin
                        ch_n    = lowest_ch(above);
                        go_ping = 1'b1;
                    end else if (cont && ch_en != '0) begin
                        // New sweep: the mask is refreshed from ch_en.
                        mask_n  = ch_en;
                        ch_n    = lowest_ch(ch_en);
                        go_ping = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Range clock: cm_cnt = floor(t / CM_TICKS) with t = 0 at first PING cycle.
        if (state == S_PING || state == S_LISTEN) begin
            if (pre == PRE_W'(CM_TICKS - 1)) begin
                pre_n = '0;
                cm_n  = cm_cnt + DIST_W'(1);
            end else begin
                pre_n = pre + PRE_W'(1);
            end
        end

        if (go_ping) begin
            state_n = S_PING;
            tmr_n   = '0;
            hidx_n  = '0;
            pre_n   = '0;
            cm_n    = '0;
        end
    end

    // Carrier is high on even half-periods, so the burst starts high.
    always_comb begin
        sig_mod = '0;
        if (state == S_PING) sig_mod[ch] = ~half_idx[0];
    end

    assign busy         = (state != S_IDLE);
    assign dist_valid   = (state == S_REPORT);
    assign dist_ch      = res_ch;
    assign dist_cm      = res_cm;
    assign dist_timeout = res_to;

endmodule
